// File: rtl/simon_pkg.sv
// Shared definitions for the Simon sequence engine.
//   DEF_SEED / DEF_TAPS : default LFSR seed and feedback mask (bits 31 and 21)
//   DEF_SYM_W           : default symbol width (4 colours)
//   sym_t               : symbol type at the default width
//   seq_state_e         : playback FSM states
package simon_pkg;

  localparam logic [31:0] DEF_SEED  = 32'h0000_0001;
  localparam logic [31:0] DEF_TAPS  = 32'h8020_0000;
  localparam int unsigned DEF_SYM_W = 2;

  typedef logic [DEF_SYM_W-1:0] sym_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } seq_state_e;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci-style shift-left LFSR with a configurable feedback mask and a
// runtime seed load that refuses the all-zero lock-up state.
//   clk, rst_n : clock, asynchronous active-low reset (state returns to SEED)
//   run        : advance one step this cycle
//   seed_load  : load seed_in (priority over run); zero seed falls back to SEED
//   seed_in    : runtime seed
//   state      : current LFSR state
module lfsr_core
  import simon_pkg::*;
#(
  parameter int unsigned       LFSR_W = 32,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEF_TAPS),
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEF_SEED)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (seed_load) begin
      state_d = (seed_in == '0) ? SEED : seed_in;
    end else if (run) begin
      state_d = {state_q[LFSR_W-2:0], ^(state_q & TAPS)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/simon_seq_engine.sv
// Random colour sequence generator and replay engine for the Simon game.
// Each append stores the LFSR's low symbol bits as the next sequence entry;
// rd_start replays the stored sequence over a valid/ready stream.
//   clk, rst_n          : clock, asynchronous active-low reset
//   run                 : LFSR advances this cycle
//   seed_load, seed_in  : runtime LFSR seed (zero falls back to SEED)
//   clear               : empty the store and abort playback (highest priority)
//   append              : store current symbol (IDLE only, not full)
//   rd_start            : begin playback of the stored sequence
//   out_valid/out_ready : playback stream handshake, out_sym is the symbol
//   length, full        : entries stored, store full
//   busy, done          : playback in progress, one-cycle end-of-playback pulse
module simon_seq_engine
  import simon_pkg::*;
#(
  parameter int unsigned       LFSR_W = 32,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEF_TAPS),
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEF_SEED),
  parameter int unsigned       SYM_W  = DEF_SYM_W,
  parameter int unsigned       DEPTH  = 32,
  localparam int unsigned      LEN_W  = $clog2(DEPTH + 1),
  localparam int unsigned      IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              clear,
  input  logic              append,
  input  logic              rd_start,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SYM_W-1:0]  out_sym,
  output logic [LEN_W-1:0]  length,
  output logic              full,
  output logic              busy,
  output logic              done
);

  logic [LFSR_W-1:0] lfsr_state;
  logic [SYM_W-1:0]  cur_sym;
  logic              unused_lfsr_hi;

  lfsr_core #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .SEED   (SEED)
  ) u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .state     (lfsr_state)
  );

  // Symbol is taken from the pre-update LFSR state.
  assign cur_sym        = lfsr_state[SYM_W-1:0];
  assign unused_lfsr_hi = ^lfsr_state[LFSR_W-1:SYM_W];

  seq_state_e       state_q, state_d;
  logic [LEN_W-1:0] length_q, length_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic             append_ok;

  // Flop-based store, deliberately not reset.
  logic [SYM_W-1:0] mem_q [DEPTH];

  assign full      = (length_q == LEN_W'(DEPTH));
  assign busy      = (state_q == PLAY);
  assign out_valid = (state_q == PLAY);
  assign out_sym   = (state_q == PLAY) ? mem_q[idx_q] : '0;
  assign length    = length_q;
  assign done      = done_q;

  assign append_ok = append && !full && (state_q == IDLE) && !clear;

  always_comb begin
    state_d  = state_q;
    length_d = length_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    if (clear) begin
      state_d  = IDLE;
      length_d = '0;
      idx_d    = '0;
    end else begin
      if (append_ok) begin
        length_d = length_q + LEN_W'(1);
      end
      case (state_q)
        IDLE: begin
          // length_d so a same-cycle append is part of the replay.
          if (rd_start) begin
            if (length_d != '0) begin
              state_d = PLAY;
              idx_d   = '0;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        PLAY: begin
          if (out_ready) begin
            if (LEN_W'(idx_q) == length_q - LEN_W'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      length_q <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      length_q <= length_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (append_ok) begin
      mem_q[length_q[IDX_W-1:0]] <= cur_sym;
    end
  end

endmodule
